// File: rtl/dotprod_accum.sv
// dotprod_accum: accumulation stage behind the pipelined multiplier.
// Tags (valid/last) travel alongside the multiplier so each PROD is matched
// with its issue. Successive products are summed into a dot product, and the
// finished result is presented on a valid/ready port.
// Optional feature: define DOTPROD_ACCUM_SAT_EN to clamp the sum at all-ones
// on overflow. Without it the sum wraps modulo 2^AW; OUT_OVF reports overflow
// in both builds.
module dotprod_accum #(
  parameter int P   = 12,
  parameter int AW  = 16,
  parameter int LAT = 2,
  parameter int CW  = 8
) (
  input  logic          CLK,
  input  logic          NRESET,
  input  logic          IN_VALID,
  input  logic          IN_LAST,
  output logic          IN_READY,
  input  logic [P-1:0]  PROD,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [AW-1:0] OUT_DATA,
  output logic [CW-1:0] OUT_TERMS,
  output logic          OUT_OVF
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [LAT-1:0] tag_v, tag_l;
  logic          issue;
  logic          t_v, t_l;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          emit;
  logic [AW-1:0] prod_ext;
  logic [AW:0]   sum;

  // An accepted term is only one issued while the port was ready.
  assign issue    = IN_VALID & IN_READY;
  assign t_v      = tag_v[LAT-1];
  assign t_l      = tag_l[LAT-1];
  assign prod_ext = AW'(PROD);
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};

  // The multiplier cannot stall, so issue is held off while the result port
  // is blocked or while a vector's last term is still in flight.
  assign IN_READY = !(OUT_VALID & !OUT_READY) & !(|tag_l);

  // Tag delay line: tags age one stage per edge so the oldest matches PROD.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_l[0] <= issue & IN_LAST;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and accumulator update, driven by the aligned tag.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (t_v) begin
          acc_d   = prod_ext;
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
          emit    = t_l;
          state_d = t_l ? IDLE : RUN;
        end
      end
      RUN: begin
        if (t_v) begin
          ovf_d = ovf_q | sum[AW];
`ifdef DOTPROD_ACCUM_SAT_EN
          acc_d = (ovf_q | sum[AW]) ? {AW{1'b1}} : sum[AW-1:0];
`else
          acc_d = sum[AW-1:0];
`endif
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
          if (t_l) begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Running sum, term count and overflow flag for the vector in progress.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Result port: a new emit always wins, otherwise a handshake frees it.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_TERMS <= '0;
      OUT_OVF   <= 1'b0;
    end else if (emit) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= acc_d;
      OUT_TERMS <= cnt_d;
      OUT_OVF   <= ovf_d;
    end else if (OUT_VALID & OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dotprod_accum.sv
// Directed testbench for dotprod_accum. A small delay line stands in for the
// multiplier, so the term value driven at issue appears on PROD LAT cycles later.
module tb_dotprod_accum;

  localparam int P   = 12;
  localparam int AW  = 16;
  localparam int LAT = 2;
  localparam int CW  = 8;

  logic          CLK;
  logic          NRESET;
  logic          IN_VALID;
  logic          IN_LAST;
  logic          IN_READY;
  logic [P-1:0]  PROD;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [AW-1:0] OUT_DATA;
  logic [CW-1:0] OUT_TERMS;
  logic          OUT_OVF;

  logic [P-1:0]  term;
  logic [P-1:0]  mult_pipe [LAT];

  int total = 0;
  int bad   = 0;

  dotprod_accum #(.P(P), .AW(AW), .LAT(LAT), .CW(CW)) dut (
    .CLK       (CLK),
    .NRESET    (NRESET),
    .IN_VALID  (IN_VALID),
    .IN_LAST   (IN_LAST),
    .IN_READY  (IN_READY),
    .PROD      (PROD),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_TERMS (OUT_TERMS),
    .OUT_OVF   (OUT_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in multiplier: never stalls, result appears LAT edges after sample.
  always @(posedge CLK) begin
    mult_pipe[0] <= term;
    for (int i = 1; i < LAT; i++) mult_pipe[i] <= mult_pipe[i-1];
  end
  assign PROD = mult_pipe[LAT-1];

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one term for a single cycle; it must be accepted.
  task automatic applyStimulus(input logic [P-1:0] val, input logic last);
    IN_VALID = 1'b1;
    IN_LAST  = last;
    term     = val;
    @(negedge CLK);
    checkOutput("in_ready_on_issue", 32'(IN_READY), 32'd1);
    nextCycle();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  // Called the cycle after a last term issues; checks the LAT busy cycles
  // and the result arriving LAT+1 edges after issue. Ends on a negedge.
  task automatic waitResult(input string tag, input logic [AW-1:0] d,
                            input logic [CW-1:0] n, input logic o);
    for (int i = 0; i < LAT; i++) begin
      @(negedge CLK);
      checkOutput({tag, "_busy_valid"}, 32'(OUT_VALID), 32'd0);
      checkOutput({tag, "_busy_ready"}, 32'(IN_READY), 32'd0);
      nextCycle();
    end
    @(negedge CLK);
    checkOutput({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
    checkOutput({tag, "_data"},  32'(OUT_DATA),  32'(d));
    checkOutput({tag, "_terms"}, 32'(OUT_TERMS), 32'(n));
    checkOutput({tag, "_ovf"},   32'(OUT_OVF),   32'(o));
  endtask

  initial begin
    logic [AW-1:0] exp_big;
    NRESET    = 1'b0;
    IN_VALID  = 1'b0;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b1;
    term      = '0;
    repeat (3) nextCycle();
    @(negedge CLK);
    checkOutput("rst_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_data",  32'(OUT_DATA),  32'd0);
    checkOutput("rst_terms", 32'(OUT_TERMS), 32'd0);
    checkOutput("rst_ovf",   32'(OUT_OVF),   32'd0);
    checkOutput("rst_ready", 32'(IN_READY),  32'd1);
    nextCycle();
    NRESET = 1'b1;
    nextCycle();

    $display("[TB] reset with two terms in flight");
    applyStimulus(12'd100, 1'b0);
    applyStimulus(12'd200, 1'b0);
    NRESET = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("midrst_data",  32'(OUT_DATA),  32'd0);
    checkOutput("midrst_terms", 32'(OUT_TERMS), 32'd0);
    checkOutput("midrst_ready", 32'(IN_READY),  32'd1);
    nextCycle();
    NRESET = 1'b1;
    repeat (3) nextCycle();

    $display("[TB] three-term vector 5+7+9");
    applyStimulus(12'd5, 1'b0);
    applyStimulus(12'd7, 1'b0);
    applyStimulus(12'd9, 1'b1);
    waitResult("vec3", 16'd21, 8'd3, 1'b0);
    nextCycle();
    @(negedge CLK);
    checkOutput("vec3_drop", 32'(OUT_VALID), 32'd0);
    nextCycle();

    $display("[TB] single-term vector");
    applyStimulus(12'hABC, 1'b1);
    waitResult("single", 16'h0ABC, 8'd1, 1'b0);
    nextCycle();

    $display("[TB] consumer stall for 10 cycles");
    OUT_READY = 1'b0;
    applyStimulus(12'd3, 1'b0);
    applyStimulus(12'd4, 1'b1);
    waitResult("stall", 16'd7, 8'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      IN_VALID = 1'b1;
      term     = 12'd1000;
      @(negedge CLK);
      checkOutput("stall_valid", 32'(OUT_VALID), 32'd1);
      checkOutput("stall_data",  32'(OUT_DATA),  32'd7);
      checkOutput("stall_terms", 32'(OUT_TERMS), 32'd2);
      checkOutput("stall_ready", 32'(IN_READY),  32'd0);
    end
    nextCycle();
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    checkOutput("release_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("release_ready", 32'(IN_READY),  32'd1);
    nextCycle();
    @(negedge CLK);
    checkOutput("release_drop", 32'(OUT_VALID), 32'd0);
    nextCycle();

    $display("[TB] 20 terms of 0xFFF, overflow");
`ifdef DOTPROD_ACCUM_SAT_EN
    exp_big = 16'hFFFF;
`else
    exp_big = 16'h3FEC;
`endif
    for (int i = 0; i < 20; i++) applyStimulus(12'hFFF, (i == 19));
    waitResult("sum20", exp_big, 8'd20, 1'b1);
    nextCycle();

    $display("[TB] issue held across a last term");
    IN_VALID = 1'b1;
    IN_LAST  = 1'b1;
    term     = 12'd10;
    @(negedge CLK);
    checkOutput("hold_first_ready", 32'(IN_READY), 32'd1);
    nextCycle();
    term = 12'd33;
    for (int i = 0; i < LAT; i++) begin
      @(negedge CLK);
      checkOutput("hold_blocked_ready", 32'(IN_READY),  32'd0);
      checkOutput("hold_blocked_valid", 32'(OUT_VALID), 32'd0);
      nextCycle();
    end
    @(negedge CLK);
    checkOutput("hold_reopen_ready", 32'(IN_READY),  32'd1);
    checkOutput("hold_a_valid",      32'(OUT_VALID), 32'd1);
    checkOutput("hold_a_data",       32'(OUT_DATA),  32'd10);
    checkOutput("hold_a_terms",      32'(OUT_TERMS), 32'd1);
    nextCycle();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    waitResult("hold_b", 16'd33, 8'd1, 1'b0);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
